instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscv_pkg.sv | 15 +
 rtl/instr_fetch_unit.sv | 78 +++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM state encoding and the canonical NOP.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        FAULT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: latches PC, issues one memory request,
// returns the word (or a NOP on misalignment) with a one-cycle InstrValid strobe.
module instr_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [XLEN-1:0] PC,
    input  logic            Flush,
    output logic            MemReqValid,
    input  logic            MemReqReady,
    output logic [XLEN-1:0] MemAddr,
    input  logic            MemRspValid,
    input  logic [XLEN-1:0] MemRspData,
    output logic [XLEN-1:0] Instr,
    output logic            InstrValid,
    output logic            FetchFault,
    output logic [31:0]     FetchCount
);
    import riscv_pkg::*;

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] instr_reg;
    logic [31:0]     fetch_cnt;
    logic            flush_pend;
    logic            pc_misaligned;

    assign pc_misaligned = (PC[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!Flush) state_nxt = pc_misaligned ? FAULT : REQ;
            // A flush seen while the request is pending must not cancel it;
            // the response still arrives and has to be drained.
            REQ:   if (MemReqReady) state_nxt = (Flush || flush_pend) ? DRAIN : WAIT;
            WAIT: begin
                if (MemRspValid) state_nxt = Flush ? IDLE : DONE;
                else if (Flush)  state_nxt = DRAIN;
            end
            DONE:  state_nxt = IDLE;
            FAULT: state_nxt = IDLE;
            DRAIN: if (MemRspValid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            addr_reg   <= '0;
            instr_reg  <= NOP_INSTR;
            fetch_cnt  <= '0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= (state == REQ) && !MemReqReady && (Flush || flush_pend);
            if (state == IDLE && !Flush) begin
                addr_reg <= PC;
                if (pc_misaligned) instr_reg <= NOP_INSTR;
            end
            if (state == WAIT && MemRspValid && !Flush)
                instr_reg <= MemRspData;
            if (state == DONE && !Flush)
                fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign MemReqValid = (state == REQ);
    assign MemAddr     = addr_reg;
    assign Instr       = instr_reg;
    assign InstrValid  = ((state == DONE) || (state == FAULT)) && !Flush;
    assign FetchFault  = (state == FAULT) && !Flush;
    assign FetchCount  = fetch_cnt;

endmodule
